intpol2_iq_fifo: RTL
====================

Name: intpol2_iq_fifo

Overview:
- Synchronous dual-lane (I/Q) first-word-fall-through FIFO that buffers paired I/Q samples.
- Sits directly upstream of the IQ quadratic interpolator core. It drives that core's empty flag, its two sample inputs and its read-enable return path.
- A second instance on the output side supplies the almost-full flag for the interpolator's write side.
- Both lanes share one set of pointers, so I and Q samples never misalign.

Parameters:
- DATA_WIDTH, 32: width of each lane (I and Q).
- ADDR_WIDTH, 4: pointer width; DEPTH = 2**ADDR_WIDTH entries (16 by default).
- AFULL_TH, 14: occupancy at or above which Afull_o asserts; legal range 1..DEPTH.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rstn  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush; empties the FIFO and clears the sticky flags.
- wr_en  in  1  write request for the din_I/din_Q pair.
- din_I  in  DATA_WIDTH  in-phase sample to write.
- din_Q  in  DATA_WIDTH  quadrature sample to write.
- rd_en  in  1  read request; pops the head entry.
- dout_I  out  DATA_WIDTH  head-of-FIFO I sample (FWFT).
- dout_Q  out  DATA_WIDTH  head-of-FIFO Q sample (FWFT).
- Empty_o  out  1  occupancy == 0.
- Full_o  out  1  occupancy == DEPTH.
- Afull_o  out  1  occupancy >= AFULL_TH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- ovf  out  1  sticky flag: a write was rejected.
- udf  out  1  sticky flag: a read was rejected.

Behaviour:
- Reset (rstn=1, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; ovf and udf go to 0.
  - Empty_o=1, Full_o=0, Afull_o=0.
  - Memory contents are not reset.
- Clear: clear=1 has the same effect as reset on the next posedge, takes priority over wr_en and rd_en, and accepts no write or read that cycle.
- Read accept: rd_acc = rd_en & ~Empty_o.
- Write accept: wr_acc = wr_en & (~Full_o | rd_acc).
  - A write while full is accepted only when a read is accepted in the same cycle.
- On an accepted write, at posedge:
  - mem[wr_ptr] <= {din_I, din_Q}.
  - wr_ptr increments, wrapping modulo DEPTH.
- On an accepted read, at posedge: rd_ptr increments, wrapping modulo DEPTH.
- count next value, by case:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - both, or neither: unchanged.
- Flags:
  - Empty_o, Full_o and Afull_o are combinational decodes of the count register, so they update the cycle after the causing edge.
  - There is no look-ahead.
- FWFT output:
  - dout_I/dout_Q show mem[rd_ptr] combinationally while Empty_o=0, and are forced to 0 while Empty_o=1.
  - A write into an empty FIFO becomes visible on dout and deasserts Empty_o one cycle after the write edge.
  - Latency is 1 cycle; there is no same-cycle write-through.
- Error flags:
  - ovf is set on wr_en & ~wr_acc.
  - udf is set on rd_en & Empty_o.
  - Both stay set until reset or clear.
  - A rejected request does not change pointers, count or memory.
- Simultaneous read and write:
  - When empty: the write is accepted, the read is rejected (udf set), and count becomes 1.
  - When full: both are accepted, count stays at DEPTH, and the new data lands in the slot just freed.
- Pointer wrap: after DEPTH writes and DEPTH reads, both pointers return to 0 with no disturbance to data ordering.
- Reset asserted mid-operation: state clears immediately; data in flight is discarded.

Test Plan:
- Reset, then write 3 pairs (I=1,2,3; Q=-1,-2,-3), then read 3 ->
  - Empty_o falls 1 cycle after the first write.
  - dout sequence is (1,-1), (2,-2), (3,-3).
  - Empty_o=1 and count=0 after the last read; ovf=udf=0.
- Fill 16 entries with values 0..15 ->
  - Afull_o asserts when count reaches 14.
  - Full_o asserts at count=16.
  - A 17th write is rejected: ovf=1, count stays 16, the head stays 0.
- At full, assert wr_en and rd_en together with din=(100,200) ->
  - count stays 16 and the head becomes 1.
  - After 15 further reads, dout=(100,200).
- While empty, assert rd_en alone, then rd_en and wr_en together with din=(7,8) ->
  - udf=1 and count=1.
  - dout=(7,8) on the next cycle.
- Stream 40 pairs with wr_en=1 and rd_en toggling every other cycle from cycle 2 ->
  - Output order matches input order across pointer wrap.
  - count never exceeds 16 and no data is lost while ovf=0.
- With count=5 and ovf=1, pulse clear for 1 cycle while wr_en=1 ->
  - count=0, Empty_o=1, ovf=0; the write is not stored.
- Separately, assert rstn asynchronously between edges -> all outputs return to reset values without waiting for clk.

Source files
------------

// File: rtl/intpol2_iq_fifo.sv
// Dual-lane I/Q first-word-fall-through FIFO; one shared pointer pair keeps I and Q aligned.
// Latency: a write appears on dout_I/dout_Q one cycle after its edge; there is no write-through.
// Backpressure: a write while full is dropped (ovf) unless a read frees a slot in that cycle; a read while empty is dropped (udf).
module intpol2_iq_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int AFULL_TH   = 14
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din_I,
   input  logic [DATA_WIDTH-1:0] din_Q,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout_I,
   output logic [DATA_WIDTH-1:0] dout_Q,
   output logic                  Empty_o,
   output logic                  Full_o,
   output logic                  Afull_o,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  ovf,
   output logic                  udf
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_TH);

   // One storage word carries both lanes so they can never drift apart.
   typedef struct packed {
      logic [DATA_WIDTH-1:0] i;
      logic [DATA_WIDTH-1:0] q;
   } iq_t;

   iq_t                   mem [DEPTH];
   iq_t                   head;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  rd_acc;
   logic                  wr_acc;

   // Flags are pure decodes of the occupancy register: no look-ahead.
   assign Empty_o = (count == '0);
   assign Full_o  = (count == DEPTH_CNT);
   assign Afull_o = (count >= AFULL_CNT);

   // A full FIFO still takes a write when the same cycle pops the head.
   // Clear wins over both requests, so nothing is accepted while it is high.
   assign rd_acc = rd_en & ~Empty_o & ~clear;
   assign wr_acc = wr_en & (~Full_o | (rd_en & ~Empty_o)) & ~clear;

   // FWFT head: the entry under rd_ptr, forced to zero while empty.
   assign head   = mem[rd_ptr];
   assign dout_I = Empty_o ? '0 : head.i;
   assign dout_Q = Empty_o ? '0 : head.q;

   // Storage array is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= '{i: din_I, q: din_Q};
      end
   end

   // Pointers wrap naturally at DEPTH through their ADDR_WIDTH width.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Occupancy moves only when exactly one side is accepted.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else begin
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags record any rejected request until reset or clear.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else if (clear) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (wr_en & ~wr_acc)  ovf <= 1'b1;
         if (rd_en & Empty_o)  udf <= 1'b1;
      end
   end

endmodule
